// File: rtl/fifo_key_ctrl_pkg.sv
// Shared definitions for the FIFO push-button front end.
// Contents: FSM state encoding and the default data width / debounce length.
package fifo_key_ctrl_pkg;

  localparam int DATA_W_DEF          = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_READ     = 3'd2,
    S_CAPTURE  = 3'd3,
    S_WAIT_REL = 3'd4
  } state_t;

endpackage

// File: rtl/fifo_key_ctrl_if.sv
// Bus between the key controller and the FIFO core.
// Signals:
//   wrreq  controller -> core  write strobe
//   rdreq  controller -> core  read strobe
//   data   controller -> core  write data
//   full   core -> controller  FIFO full flag
//   empty  core -> controller  FIFO empty flag
//   q      core -> controller  read data, valid the cycle after rdreq
// Modports: master = controller side, slave = FIFO core side.
interface fifo_key_ctrl_if #(
  parameter int DATA_W = fifo_key_ctrl_pkg::DATA_W_DEF
);

  logic              wrreq;
  logic              rdreq;
  logic [DATA_W-1:0] data;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] q;

  modport master (
    output wrreq,
    output rdreq,
    output data,
    input  full,
    input  empty,
    input  q
  );

  modport slave (
    input  wrreq,
    input  rdreq,
    input  data,
    output full,
    output empty,
    output q
  );

endinterface

// File: rtl/fifo_key_ctrl_key_debounce.sv
// Synchronizes and debounces one active-low push-button.
// Ports:
//   clk, reset  single clock, synchronous active-high reset
//   key_n       raw button pin (active-low, asynchronous)
//   level       debounced level, 1 = released
//   press       one-cycle pulse on a debounced release->press transition
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [1:0]       sync_r;
  logic [1:0]       valid_r;
  logic [CNT_W-1:0] cnt_r;
  logic             level_r;
  logic             press_r;
  logic             armed_r;

  // Synchronizer, stability counter, debounced level and press pulse.
  // sync_r resets to "released", so valid_r tracks when sync_r[1] really
  // reflects the pin again. armed_r only sets once a genuinely released key
  // has been seen, so a key held through reset debounces low silently and
  // needs a release and a fresh press before it can produce a press pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r  <= 2'b11;
      valid_r <= 2'b00;
      cnt_r   <= CNT_ZERO;
      level_r <= 1'b1;
      press_r <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      sync_r  <= {sync_r[0], key_n};
      valid_r <= {valid_r[0], 1'b1};
      armed_r <= armed_r | (valid_r[1] & sync_r[1] & level_r);
      if (sync_r[1] != level_r) begin
        if (cnt_r == CNT_LAST) begin
          level_r <= sync_r[1];
          cnt_r   <= CNT_ZERO;
          press_r <= armed_r & ~sync_r[1];
        end else begin
          cnt_r   <= cnt_r + CNT_ONE;
          press_r <= 1'b0;
        end
      end else begin
        cnt_r   <= CNT_ZERO;
        press_r <= 1'b0;
      end
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/fifo_key_ctrl.sv
// Push-button front end for the 8-bit single-clock FIFO.
// Turns two debounced active-low keys into single-cycle write/read strobes,
// guards them against full/empty, flags overflow/underflow attempts and
// latches the value returned by a read.
// Ports:
//   clock_50mhz, reset  clock and synchronous active-high reset
//   key_wr_n, key_rd_n  raw write/read buttons (active-low, asynchronous)
//   data_in             switch value to write
//   fifo                master side of the FIFO bus (strobes, data, flags, q)
//   data_out            last value read from the FIFO
//   ovf_err, udf_err    sticky overflow / underflow attempt flags
//   busy                controller is not idle
module fifo_key_ctrl
  import fifo_key_ctrl_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic              clock_50mhz,
  input  logic              reset,
  input  logic              key_wr_n,
  input  logic              key_rd_n,
  input  logic [DATA_W-1:0] data_in,
  fifo_key_ctrl_if.master   fifo,
  output logic [DATA_W-1:0] data_out,
  output logic              ovf_err,
  output logic              udf_err,
  output logic              busy
);

  logic wr_level_s;
  logic wr_press_s;
  logic rd_level_s;
  logic rd_press_s;

  state_t state_r;
  state_t next_state_s;
  logic   accept_wr_s;
  logic   ovf_set_s;
  logic   udf_set_s;

  logic              wrreq_r;
  logic              rdreq_r;
  logic              busy_r;
  logic              ovf_r;
  logic              udf_r;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] data_out_r;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_wr_key (
    .clk   (clock_50mhz),
    .reset (reset),
    .key_n (key_wr_n),
    .level (wr_level_s),
    .press (wr_press_s)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rd_key (
    .clk   (clock_50mhz),
    .reset (reset),
    .key_n (key_rd_n),
    .level (rd_level_s),
    .press (rd_press_s)
  );

  // FSM state register.
  always_ff @(posedge clock_50mhz) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode. Presses are only looked at in IDLE, write beats a
  // read press in the same cycle, and full/empty are judged in that cycle.
  always_comb begin
    next_state_s = state_r;
    accept_wr_s  = 1'b0;
    ovf_set_s    = 1'b0;
    udf_set_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (wr_press_s) begin
          if (fifo.full) begin
            ovf_set_s    = 1'b1;
            next_state_s = S_WAIT_REL;
          end else begin
            accept_wr_s  = 1'b1;
            next_state_s = S_WRITE;
          end
        end else if (rd_press_s) begin
          if (fifo.empty) begin
            udf_set_s    = 1'b1;
            next_state_s = S_WAIT_REL;
          end else begin
            next_state_s = S_READ;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_WRITE:   next_state_s = S_WAIT_REL;
      S_READ:    next_state_s = S_CAPTURE;
      S_CAPTURE: next_state_s = S_WAIT_REL;
      S_WAIT_REL: begin
        if (wr_level_s && rd_level_s) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_WAIT_REL;
        end
      end
      default:   next_state_s = S_IDLE;
    endcase
  end

  // Registered outputs. Strobes and busy are decoded from the next state so
  // they line up with the WRITE/READ cycles without a combinational path.
  always_ff @(posedge clock_50mhz) begin
    if (reset) begin
      wrreq_r    <= 1'b0;
      rdreq_r    <= 1'b0;
      busy_r     <= 1'b0;
      ovf_r      <= 1'b0;
      udf_r      <= 1'b0;
      data_r     <= {DATA_W{1'b0}};
      data_out_r <= {DATA_W{1'b0}};
    end else begin
      wrreq_r <= (next_state_s == S_WRITE);
      rdreq_r <= (next_state_s == S_READ);
      busy_r  <= (next_state_s != S_IDLE);
      ovf_r   <= ovf_r | ovf_set_s;
      udf_r   <= udf_r | udf_set_s;
      if (accept_wr_s) begin
        data_r <= data_in;
      end
      // fifo.q is valid in CAPTURE, the cycle after the read strobe.
      if (state_r == S_CAPTURE) begin
        data_out_r <= fifo.q;
      end
    end
  end

  assign fifo.wrreq = wrreq_r;
  assign fifo.rdreq = rdreq_r;
  assign fifo.data  = data_r;
  assign data_out   = data_out_r;
  assign ovf_err    = ovf_r;
  assign udf_err    = udf_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_fifo_key_ctrl.sv
// Directed self-checking bench for fifo_key_ctrl with a 4-cycle debounce.
module tb_fifo_key_ctrl;

  logic       clk;
  logic       reset;
  logic       key_wr_n;
  logic       key_rd_n;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       ovf_err;
  logic       udf_err;
  logic       busy;

  int total;
  int bad;
  int wr_cnt;
  int rd_cnt;
  int wr0;
  int rd0;
  int lat;
  logic prev_strobe;

  fifo_key_ctrl_if #(.DATA_W(8)) fifo_bus ();

  fifo_key_ctrl #(.DATA_W(8), .DEBOUNCE_CYCLES(4)) dut (
    .clock_50mhz (clk),
    .reset       (reset),
    .key_wr_n    (key_wr_n),
    .key_rd_n    (key_rd_n),
    .data_in     (data_in),
    .fifo        (fifo_bus),
    .data_out    (data_out),
    .ovf_err     (ovf_err),
    .udf_err     (udf_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor: counts pulses and rejects back-to-back strobes.
  initial begin
    wr_cnt      = 0;
    rd_cnt      = 0;
    prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (fifo_bus.wrreq === 1'b1) wr_cnt++;
      if (fifo_bus.rdreq === 1'b1) rd_cnt++;
      if (prev_strobe) begin
        total++;
        assert (!(fifo_bus.wrreq === 1'b1 || fifo_bus.rdreq === 1'b1)) else begin
          bad++;
          $error("FAIL back_to_back: observed=strobe expected=no strobe");
        end
      end
      prev_strobe = (fifo_bus.wrreq === 1'b1) || (fifo_bus.rdreq === 1'b1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Polls (bounded) for a strobe, returning cycles since the key went down.
  task automatic wait_strobe(input bit is_wr, output int cycles);
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      cycles++;
      if (is_wr ? (fifo_bus.wrreq === 1'b1) : (fifo_bus.rdreq === 1'b1)) break;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    key_wr_n = 1'b1;
    key_rd_n = 1'b1;
    data_in  = 8'h00;
    fifo_bus.full  = 1'b0;
    fifo_bus.empty = 1'b1;
    fifo_bus.q     = 8'h00;
    tick(3);

    // Reset values
    check("rst_wrreq", fifo_bus.wrreq, 0);
    check("rst_rdreq", fifo_bus.rdreq, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_udf", udf_err, 0);
    check("rst_fifo_data", fifo_bus.data, 8'h00);
    check("rst_data_out", data_out, 8'h00);
    reset = 1'b0;
    tick(5);

    // Write 0xA5: one strobe, latency 2 sync + 4 debounce + 1, +-1
    data_in = 8'hA5;
    wr0 = wr_cnt;
    key_wr_n = 1'b0;
    wait_strobe(1'b1, lat);
    check("wr_latency", (lat >= 6 && lat <= 8) ? 1 : 0, 1);
    check("wr_strobe_data", fifo_bus.data, 8'hA5);
    check("wr_busy", busy, 1);
    tick(1);
    check("wr_single_cycle", fifo_bus.wrreq, 0);
    tick(3);
    key_wr_n = 1'b1;
    check("wr_busy_held", busy, 1);
    tick(12);
    check("wr_busy_released", busy, 0);
    check("wr_count", wr_cnt - wr0, 1);
    data_in = 8'h11;
    tick(2);
    check("wr_data_stable", fifo_bus.data, 8'hA5);

    // Bounce: 2 low / 2 high never reaches 4 stable cycles
    wr0 = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      key_wr_n = 1'b0;
      tick(2);
      key_wr_n = 1'b1;
      tick(2);
    end
    tick(10);
    check("bounce_no_write", wr_cnt - wr0, 0);
    check("bounce_busy", busy, 0);

    // Read 0x3C: rdreq at P+1, data_out new from P+3
    fifo_bus.empty = 1'b0;
    fifo_bus.q     = 8'h3C;
    rd0 = rd_cnt;
    key_rd_n = 1'b0;
    wait_strobe(1'b0, lat);
    check("rd_latency", (lat >= 6 && lat <= 8) ? 1 : 0, 1);
    check("rd_dout_p1", data_out, 8'h00);
    tick(1);
    check("rd_single_cycle", fifo_bus.rdreq, 0);
    check("rd_dout_p2", data_out, 8'h00);
    tick(1);
    check("rd_dout_p3", data_out, 8'h3C);
    tick(4);
    key_rd_n = 1'b1;
    tick(12);
    check("rd_count", rd_cnt - rd0, 1);
    check("rd_busy_released", busy, 0);

    // Overflow guard
    fifo_bus.full = 1'b1;
    wr0 = wr_cnt;
    key_wr_n = 1'b0;
    tick(10);
    key_wr_n = 1'b1;
    tick(12);
    check("ovf_no_strobe", wr_cnt - wr0, 0);
    check("ovf_set", ovf_err, 1);
    check("ovf_udf_clear", udf_err, 0);
    check("ovf_busy", busy, 0);
    fifo_bus.full = 1'b0;

    // Underflow guard
    fifo_bus.empty = 1'b1;
    rd0 = rd_cnt;
    key_rd_n = 1'b0;
    tick(10);
    key_rd_n = 1'b1;
    tick(12);
    check("udf_no_strobe", rd_cnt - rd0, 0);
    check("udf_set", udf_err, 1);
    check("udf_ovf_sticky", ovf_err, 1);
    fifo_bus.empty = 1'b0;

    // Simultaneous press: write wins, read discarded
    data_in = 8'h5A;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    key_wr_n = 1'b0;
    key_rd_n = 1'b0;
    tick(12);
    key_wr_n = 1'b1;
    key_rd_n = 1'b1;
    tick(12);
    check("sim_wr_count", wr_cnt - wr0, 1);
    check("sim_rd_count", rd_cnt - rd0, 0);
    check("sim_fifo_data", fifo_bus.data, 8'h5A);
    check("sim_idle", busy, 0);
    check("sim_ovf_sticky", ovf_err, 1);
    check("sim_udf_sticky", udf_err, 1);

    // Reset in the READ cycle, key held through reset release
    key_rd_n = 1'b0;
    wait_strobe(1'b0, lat);
    check("mid_rd_seen", fifo_bus.rdreq, 1);
    reset = 1'b1;
    tick(1);
    check("mid_rdreq", fifo_bus.rdreq, 0);
    check("mid_wrreq", fifo_bus.wrreq, 0);
    check("mid_busy", busy, 0);
    check("mid_ovf", ovf_err, 0);
    check("mid_udf", udf_err, 0);
    check("mid_fifo_data", fifo_bus.data, 8'h00);
    check("mid_data_out", data_out, 8'h00);
    reset = 1'b0;
    tick(1);
    rd0 = rd_cnt;
    tick(20);
    check("held_no_press", rd_cnt - rd0, 0);
    check("held_busy", busy, 0);
    key_rd_n = 1'b1;
    tick(12);
    key_rd_n = 1'b0;
    tick(10);
    key_rd_n = 1'b1;
    tick(12);
    check("repress_count", rd_cnt - rd0, 1);
    check("repress_data_out", data_out, 8'h3C);
    check("repress_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
